// File: rtl/add16u_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : add16u_rr_sched
// Brief    : Round-robin scheduler time-sharing one external combinational
//            W-bit approximate adder among N_REQ requesters; one tagged,
//            registered response per accepted request.
// Revision : 1.0 - initial release
// ============================================================================
module add16u_rr_sched #(
    parameter int  N_REQ = 4,
    parameter int  W     = 16,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    input  logic [W:0]         add_o,
    output logic               rsp_valid,
    output logic [W:0]         rsp_data,
    output logic [IDW-1:0]     rsp_id,
    input  logic               rsp_ready,
    output logic [15:0]        ops_cnt
);

    localparam logic [15:0]    c_cnt_max = 16'hFFFF;
    localparam logic [IDW-1:0] c_id_last = IDW'(N_REQ - 1);

    logic               r_rsp_valid;
    logic [W:0]         r_rsp_data;
    logic [IDW-1:0]     r_rsp_id;
    logic [IDW-1:0]     r_rr_ptr;
    logic [15:0]        r_ops_cnt;

    logic               w_can_issue;
    logic               w_found;
    logic               w_grant;
    logic [IDW-1:0]     w_gnt;
    logic [IDW-1:0]     w_cand;
    int                 w_sum;
    logic [N_REQ-1:0]   w_req_ready;
    logic [W-1:0]       w_add_a;
    logic [W-1:0]       w_add_b;

    assign w_can_issue = ~r_rsp_valid | rsp_ready;

    // Rotating priority search starting at r_rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        w_sum   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            w_cand = IDW'(w_sum);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_grant = rst_n & w_found & w_can_issue;

    // Operands are zeroed when nothing is granted to keep the adder quiet.
    always_comb begin
        w_req_ready = '0;
        w_add_a     = '0;
        w_add_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant && (w_gnt == IDW'(i))) begin
                w_req_ready[i] = 1'b1;
                w_add_a        = req_a[i*W +: W];
                w_add_b        = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rr_ptr    <= '0;
            r_ops_cnt   <= '0;
        end else if (w_grant) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= add_o;
            r_rsp_id    <= w_gnt;
            r_rr_ptr    <= (w_gnt == c_id_last) ? '0 : w_gnt + IDW'(1);
            if (r_ops_cnt != c_cnt_max) begin
                r_ops_cnt <= r_ops_cnt + 16'd1;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign req_ready = w_req_ready;
    assign add_a     = w_add_a;
    assign add_b     = w_add_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign ops_cnt   = r_ops_cnt;

endmodule
`default_nettype wire

// File: tb/tb_add16u_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_add16u_rr_sched
// Brief    : Self-checking bench for add16u_rr_sched against a queue-free
//            behavioural model of the round-robin scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add16u_rr_sched;

    localparam int N = 4;
    localparam int W = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_ready;
    logic [W-1:0]    add_a;
    logic [W-1:0]    add_b;
    logic [W:0]      add_o;
    logic            rsp_valid;
    logic [W:0]      rsp_data;
    logic [1:0]      rsp_id;
    logic            rsp_ready;
    logic [15:0]     ops_cnt;

    logic [W-1:0]    ra [N];
    logic [W-1:0]    rb [N];
    logic            fixed_mode;

    int checks = 0;
    int errors = 0;

    // Model state
    int          m_ptr;
    logic        m_valid;
    logic [W:0]  m_data;
    int          m_id;
    int          m_cnt;

    int          last_grant;
    logic [N-1:0] seen_ready;
    logic [W-1:0] seen_a;
    logic [W-1:0] seen_b;

    add16u_rr_sched #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_o     (add_o),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .ops_cnt   (ops_cnt)
    );

    // External adder: exact reference, or a fixed constant for pass-through.
    assign add_o = fixed_mode ? 17'h0AAAA : ({1'b0, add_a} + {1'b0, add_b});

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = ra[i];
            req_b[i*W +: W] = rb[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock: entered just after a negedge with stimulus applied.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        #1;
        g = -1;
        if (rst_n && (!m_valid || rsp_ready)) g = model_winner();
        exp_ready = '0;
        exp_a = '0;
        exp_b = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_a = ra[g];
            exp_b = rb[g];
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("add_a", 32'(add_a), 32'(exp_a));
        check("add_b", 32'(add_b), 32'(exp_b));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_data", 32'(rsp_data), 32'(m_data));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("ops_cnt", 32'(ops_cnt), 32'(m_cnt));
        seen_ready = req_ready;
        seen_a = add_a;
        seen_b = add_b;
        last_grant = g;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_cnt = 0;
        end else if (g >= 0) begin
            m_data  = fixed_mode ? 17'h0AAAA : ({1'b0, ra[g]} + {1'b0, rb[g]});
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
            if (m_cnt < 65535) m_cnt++;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        fixed_mode = 1'b0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_cnt = 0;
        last_grant = -1;
        @(negedge clk);
        cycle();
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_ops_cnt", 32'(ops_cnt), 32'h0);
        rst_n = 1'b1;

        // Single request, exact adder
        ra[0] = 16'h0003; rb[0] = 16'h0004; req_valid = 4'b0001;
        cycle();
        check("single_ready", 32'(seen_ready), 32'h1);
        req_valid = '0;
        check("single_data", 32'(rsp_data), 32'h00007);
        check("single_id", 32'(rsp_id), 32'h0);
        check("single_cnt", 32'(ops_cnt), 32'h1);
        cycle();

        // All four held valid: strict rotation
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < N; j++) begin ra[j] = 16'($urandom); rb[j] = 16'($urandom); end
            cycle();
            check("rr_order", 32'(last_grant), 32'(i % 4));
        end
        check("rr_cnt", 32'(ops_cnt), 32'd8);
        req_valid = '0;
        cycle();

        // Backpressure
        do_reset();
        ra[0] = 16'hFFFF; rb[0] = 16'h0001; req_valid = 4'b0001;
        cycle();
        req_valid = 4'b0010; ra[1] = 16'h1234; rb[1] = 16'h0101;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_data", 32'(rsp_data), 32'h10000);
            check("bp_ready", 32'(seen_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_regrant", 32'(last_grant), 32'd1);
        check("bp_newdata", 32'(rsp_data), 32'h01335);
        req_valid = '0;
        cycle();

        // Wrap-around with rr_ptr = 2
        do_reset();
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b0011;
        cycle();
        check("wrap_first", 32'(last_grant), 32'd0);
        req_valid = 4'b0010;
        cycle();
        check("wrap_second", 32'(last_grant), 32'd1);
        req_valid = '0;

        // Pass-through with a fixed adder result
        fixed_mode = 1'b1;
        ra[2] = 16'($urandom); rb[2] = 16'($urandom); req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        check("pass_data", 32'(rsp_data), 32'h0AAAA);
        cycle();
        check("idle_add_a", 32'(seen_a), 32'h0);
        check("idle_add_b", 32'(seen_b), 32'h0);
        fixed_mode = 1'b0;

        // Counter saturation, then reset with a pending response
        force dut.r_ops_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        cycle();
        release dut.r_ops_cnt;
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("sat_cnt", 32'(ops_cnt), 32'hFFFF);
        end
        req_valid = '0;
        rst_n = 1'b0;
        cycle();
        check("rst_mid_valid", 32'(rsp_valid), 32'h0);
        check("rst_mid_cnt", 32'(ops_cnt), 32'h0);
        rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rsp_ready = ($urandom % 4) != 0;
            rst_n = ($urandom % 150) != 0;
            cycle();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && (last_grant == i || ($urandom % 32) == 0)) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && ($urandom % 3) == 0) begin
                    req_valid[i] = 1'b1;
                    ra[i] = 16'($urandom);
                    rb[i] = 16'($urandom);
                end
            end
        end
        rst_n = 1'b1;
        req_valid = '0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add16u_rr_sched.md
Name: add16u_rr_sched

Overview:
Round-robin scheduler that time-shares one combinational 16-bit approximate adder (add16u family, 16+16 -> 17 bits) between N_REQ requesters. The adder sits outside this block: the scheduler drives its operands and captures its 17-bit sum. Each granted request gets one registered response tagged with the requester index. Sits between the processing lanes and the shared approximate adder in the FPGA evaluation datapath.

Parameters:
N_REQ, 4, number of requesters (2..16)
W, 16, operand width; the sum is W+1 bits
IDW, $clog2(N_REQ), requester-id width (derived, not overridable)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  N_REQ  per-requester request valid
req_a  in  N_REQ*W  packed operand A; requester i uses bits [i*W +: W]
req_b  in  N_REQ*W  packed operand B, same packing as req_a
req_ready  out  N_REQ  one-hot grant; the request is accepted when req_valid[i] & req_ready[i]
add_a  out  W  operand A to the shared adder
add_b  out  W  operand B to the shared adder
add_o  in  W+1  sum returned by the shared adder, combinational from add_a/add_b
rsp_valid  out  1  response register holds a result
rsp_data  out  W+1  captured add_o
rsp_id  out  IDW  index of the requester that owns rsp_data
rsp_ready  in  1  consumer accepts the response
ops_cnt  out  16  accepted operations since reset, saturating at 0xFFFF

Behaviour:
- Reset (rst_n=0 at a clock edge): rsp_valid=0, rsp_data=0, rsp_id=0, ops_cnt=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Output slot has two states. EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_issue = ~rsp_valid | rsp_ready. A FULL slot that drains in a cycle can accept a new issue in that same cycle, so back-to-back throughput is 1 op/cycle.
- Arbitration is combinational each cycle. Search req_valid starting at index rr_ptr, ascending and wrapping. The first set bit is the winner g. req_ready = onehot(g) if can_issue and any req_valid is set; otherwise 0.
- req_ready depends combinationally on req_valid and rsp_ready. A requester holds req_valid, req_a and req_b stable until it is accepted. Dropping req_valid before acceptance is allowed and simply removes that requester from arbitration.
- add_a/add_b = req_a/req_b of g when a grant is given; otherwise 0. This keeps the adder input quiet so FPGA power measurements stay meaningful.
- Each grant does the following at the clock edge:
  - rsp_data <= add_o, rsp_id <= g, rsp_valid <= 1
  - rr_ptr <= (g+1) mod N_REQ
  - ops_cnt increments and holds at 0xFFFF
- Drain with no grant (rsp_valid & rsp_ready, no issue): rsp_valid <= 0. rsp_data and rsp_id keep their old values.
- FULL with rsp_ready=0: rsp_valid, rsp_data and rsp_id hold. req_ready=0.
- Latency: the result is visible on rsp_* the cycle after acceptance.
- The scheduler never modifies add_o. Approximation error belongs to the adder, not to this block.
- rr_ptr changes only on a grant. No requester waits more than N_REQ-1 grants while it holds req_valid.
- Reset mid-operation: the pending response is discarded and no req_ready is asserted during reset. Requesters must re-present their requests.

Test Plan:
- Reset then a single request (adder is an exact reference model): req_valid=0001, a0=0x0003, b0=0x0004, rsp_ready=1. Expected: req_ready=0001 in cycle 0; in cycle 1 rsp_valid=1, rsp_data=0x00007, rsp_id=0, ops_cnt=1.
- All four requesters held valid, rsp_ready=1, 8 cycles. Expected grant order 0,1,2,3,0,1,2,3, one response per cycle, ops_cnt=8.
- Backpressure: rsp_ready=0 after the first grant (a=0xFFFF, b=0x0001). Expected: rsp_data=0x10000 held for 5 cycles, req_ready=0. Raising rsp_ready gives a drain and a new grant in the same cycle.
- rr_ptr=2 with req_valid=0011. Expected grant to 0, then rr_ptr=1 and the next grant goes to 1 (wrap-around).
- Pass-through: substitute an adder model returning a fixed 0x0AAAA. Expected rsp_data=0x0AAAA regardless of operands, and add_a/add_b=0 in idle cycles.
- ops_cnt preloaded via force to 0xFFFE, then 3 grants. Expected 0xFFFF, 0xFFFF, 0xFFFF. Assert rst_n=0 with rsp_valid=1: next cycle rsp_valid=0 and ops_cnt=0.
